// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder sequencer.
// State encoding and counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_from_ha.sv
// One-bit full adder built from two half adders
// and an OR of their carries.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa_from_ha (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .x(x),
    .y(y),
    .s(s0),
    .c(c0)
  );

  half_adder u_ha1 (
    .x(s0),
    .y(ci),
    .s(s),
    .c(c1)
  );

  assign co = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell
// processes the operands LSB first.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  fa_from_ha u_fa (
    .x(sa[0]),
    .y(sb[0]),
    .ci(carry),
    .s(s_bit),
    .co(c_bit)
  );

  assign res_next = {s_bit, res[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt == LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa      <= '0;
      sb      <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          res   <= res_next;
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          // result becomes visible only when the last bit lands
          if (cnt == LAST) begin
            sum  <= res_next;
            cout <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl against
// a cycle-timeline model of a + b + cin.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .cin(cin),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
  );

  always #5 clk = ~clk;

  // t = cycles since the accepting edge; 0 means idle
  int           t = 0;
  logic [W:0]   pend = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      m_sum = '0;
      m_cout = 1'b0;
    end else if (t == 0) begin
      if (start) begin
        pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        t = 1;
      end
    end else if (t == W + 1) begin
      t = 0;
    end else begin
      t = t + 1;
      if (t == W + 1) begin
        m_sum = pend[W-1:0];
        m_cout = pend[W];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("busy", 64'(busy), 64'(t >= 1 && t <= W));
      check("done", 64'(done), 64'(t == W + 1));
      check("sum", 64'(sum), 64'(m_sum));
      check("cout", 64'(cout), 64'(m_cout));
    end
  end

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) check("timeout", 64'(done), 64'(1));
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic [W-1:0] es,
                        input logic ec, input bit lat);
    int n;
    @(negedge clk);
    a = xa;
    b = xb;
    cin = xc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    if (lat) check("latency", 64'(n), 64'(W + 1));
    check("op_sum", 64'(sum), 64'(es));
    check("op_cout", 64'(cout), 64'(ec));
  endtask

  initial begin
    int n;
    int n2;
    logic [W:0] r;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    rst = 1'b0;

    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b1);

    // disturb operands and start mid-run
    @(negedge clk);
    a = 8'hA5;
    b = 8'h5A;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("dist_sum", 64'(sum), 64'(8'h00));
    check("dist_cout", 64'(cout), 64'(1));
    repeat (3) @(negedge clk);
    check("dist_idle", 64'(busy), 64'(0));

    // start held high
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    wait_done(n);
    check("held1_sum", 64'(sum), 64'(8'h03));
    a = 8'h10;
    b = 8'h20;
    @(negedge clk);
    check("held1_pulse", 64'(done), 64'(0));
    n2 = 1;
    while (done !== 1'b1 && n2 < 30) begin
      @(negedge clk);
      n2++;
    end
    start = 1'b0;
    check("held_gap", 64'(n2), 64'(W + 2));
    check("held2_sum", 64'(sum), 64'(8'h30));
    @(negedge clk);
    check("held2_pulse", 64'(done), 64'(0));

    // reset on the 4th run cycle
    @(negedge clk);
    a = 8'h77;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    rst = 1'b0;
    run_op(8'h77, 8'h11, 1'b0, 8'h88, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      r = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc, r[W-1:0], r[W], 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Sequencer that time-shares a single one-bit full-adder cell to add two WIDTH-bit operands bit-serially, LSB first. The full-adder cell is built from two half adders and an OR gate. The block accepts operands with a start/busy/done handshake and presents a registered sum and carry-out. It sits between operand registers and any consumer that needs a low-area adder, trading latency for gate count.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request to begin an addition; sampled only in IDLE
a      input   WIDTH  operand A; captured on the accepted start edge
b      input   WIDTH  operand B; captured on the accepted start edge
cin    input   1      carry-in; captured on the accepted start edge
busy   output  1      high while bits are being processed (RUN state)
done   output  1      one-cycle pulse; sum/cout valid from this cycle
sum    output  WIDTH  registered result; holds until the next completion
cout   output  1      registered carry-out; holds until the next completion

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0; internal shift registers, carry register and bit counter all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a and b into shift regs, load cin into the carry reg, clear counter, go to RUN.
  - start=0: stay in IDLE.
- RUN, one bit per edge:
  - Full-adder cell inputs are sa[0], sb[0], carry.
  - Cell sum bit shifts into the MSB of the result shift reg (right shift); cell carry updates the carry reg.
  - sa and sb shift right by 1.
  - Counter increments each edge.
  - On the edge where counter==WIDTH-1: copy the completed result shift reg (including the bit produced on that edge) to sum, final carry to cout, and go to DONE.
- DONE: done=1 for exactly this one cycle; next edge returns to IDLE.
- busy=1 iff state==RUN. done=1 iff state==DONE.
- Latency: start accepted at edge E0; RUN occupies edges E1..E_WIDTH; done high in the cycle following E_WIDTH.
  - Completion is WIDTH+1 cycles after acceptance.
  - Throughput is one op per WIDTH+2 cycles when start is held high.
- start during RUN or DONE is ignored: no re-capture, and no effect on the in-flight operation. Changes to a/b/cin during RUN have no effect.
- sum and cout change only on the edge that enters DONE, never during RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- rst mid-RUN: abort immediately, go to IDLE, all outputs zeroed, no done pulse. rst has priority over start in the same cycle.
- Counter width is $clog2(WIDTH). The counter never wraps during a legal operation.

Decomposition:
- Package serial_adder_pkg:
  - localparam state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - function returning counter width from WIDTH.
- Sub-module fa_from_ha:
  - Combinational full-adder cell: two half-adder instances plus an OR of the two carries.
  - Ports x, y, ci, s, co.
  - Instantiated once inside serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0, start pulse -> busy for 8 cycles, done at cycle 9 after acceptance, sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. a=0x3C, b=0x0F, cin=1 -> sum=0x4C, cout=0.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Change a/b and pulse start mid-RUN -> result unchanged, no extra operation started.
- start held high with operand pairs (0x01,0x02) then (0x10,0x20) -> done pulses 10 cycles apart, sums 0x03 then 0x30, done exactly one cycle wide each time.
- rst asserted on the 4th RUN cycle of a=0x77, b=0x11 -> next cycle busy=0, sum=0, cout=0, no done; a subsequent start completes normally.
- 1000 random (a,b,cin) ops compared against a+b+cin reference -> all match, and sum stays stable between done pulses.
